// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation codes, FSM states and flag layout.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    // Codes 001 and 111 have no ALU meaning and are answered with an error.
    function automatic logic cntrl_legal(input logic [2:0] cntrl);
        return !((cntrl == 3'b001) || (cntrl == 3'b111));
    endfunction

endpackage

// File: rtl/alu_rr_pick2.sv
// Two-way grant picker: a lone requester always wins, a tie goes to the pointer.
module alu_rr_pick2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       any,
    output logic       id
);

    always_comb begin
        any = |valid;
        if (&valid) begin
            id = ptr;
        end else begin
            id = valid[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one operation at a time.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; grants one and latches its operands
// EXEC  | latched operands drive the ALU; result, error and flags are captured
// RESP  | response presented until rsp_ready
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [2:0]  req0_cntrl,
    input  logic        req0_setflags,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [2:0]  req1_cntrl,
    input  logic        req1_setflags,
    output logic [63:0] alu_A,
    output logic [63:0] alu_B,
    output logic [2:0]  alu_cntrl,
    input  logic [63:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_error,
    output logic [3:0]  flags
);

    state_t      state, state_nxt;
    logic        pick_any, pick_id, ptr, grant;
    logic [63:0] op_a, op_b;
    logic [2:0]  op_cntrl;
    logic        op_setflags, op_id;
    flags_t      flags_q;

    alu_rr_pick2 u_pick (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .any   (pick_any),
        .id    (pick_id)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr = 1'b0;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (grant) begin
            ptr <= ~pick_id;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is gated by reset_n so it is low the moment reset asserts.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && reset_n) begin
                    grant      = 1'b1;
                    req0_ready = ~pick_id;
                    req1_ready = pick_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a        <= '0;
            op_b        <= '0;
            op_cntrl    <= '0;
            op_setflags <= 1'b0;
            op_id       <= 1'b0;
        end else if (grant) begin
            op_a        <= pick_id ? req1_a : req0_a;
            op_b        <= pick_id ? req1_b : req0_b;
            op_cntrl    <= pick_id ? req1_cntrl : req0_cntrl;
            op_setflags <= pick_id ? req1_setflags : req0_setflags;
            op_id       <= pick_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            rsp_error  <= 1'b0;
            flags_q    <= '0;
        end else if (state == EXEC) begin
            rsp_id <= op_id;
            if (cntrl_legal(op_cntrl)) begin
                rsp_result <= alu_result;
                rsp_error  <= 1'b0;
                if (op_setflags) begin
                    case (op_cntrl)
                        ALU_ADD, ALU_SUBTRACT:
                            flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
                        ALU_AND, ALU_OR, ALU_XOR:
                            flags_q <= {alu_negative, alu_zero, 1'b0, 1'b0};
                        default: ;
                    endcase
                end
            end else begin
                rsp_result <= '0;
                rsp_error  <= 1'b1;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign alu_A     = op_a;
    assign alu_B     = op_b;
    assign alu_cntrl = op_cntrl;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: behavioural ALU, transaction-level arbitration model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_cntrl = '0, req1_cntrl = '0;
    logic        req0_setflags = 1'b0, req1_setflags = 1'b0;
    logic [63:0] alu_A, alu_B, alu_result;
    logic [2:0]  alu_cntrl;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_error;
    logic [63:0] rsp_result;
    logic [3:0]  flags;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cntrl(req0_cntrl), .req0_setflags(req0_setflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cntrl(req1_cntrl), .req1_setflags(req1_setflags),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .flags(flags)
    );

    typedef struct packed { logic [63:0] r; logic [3:0] nzvc; } alu_out_t;

    // Behavioural ALU; V/C are deliberately 1 for non-arithmetic ops and illegal codes
    // return garbage, so the arbiter must mask them itself.
    function automatic alu_out_t ref_alu(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] cn);
        alu_out_t    o;
        logic [64:0] s;
        s      = {1'b0, a} + {1'b0, b};
        o.nzvc = 4'b0011;
        case (cn)
            3'b000: o.r = b;
            3'b010: begin
                o.r       = s[63:0];
                o.nzvc[1] = (a[63] == b[63]) && (o.r[63] != a[63]);
                o.nzvc[0] = s[64];
            end
            3'b011: begin
                o.r       = a - b;
                o.nzvc[1] = (a[63] != b[63]) && (o.r[63] != a[63]);
                o.nzvc[0] = (a >= b);
            end
            3'b100:  o.r = a & b;
            3'b101:  o.r = a | b;
            3'b110:  o.r = a ^ b;
            default: o.r = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
        o.nzvc[3] = o.r[63];
        o.nzvc[2] = (o.r == 64'd0);
        return o;
    endfunction

    alu_out_t alu_o;
    always_comb alu_o = ref_alu(alu_A, alu_B, alu_cntrl);
    assign alu_result    = alu_o.r;
    assign alu_negative  = alu_o.nzvc[3];
    assign alu_zero      = alu_o.nzvc[2];
    assign alu_overflow  = alu_o.nzvc[1];
    assign alu_carry_out = alu_o.nzvc[0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct packed { logic id; logic [63:0] res; logic err; logic [3:0] fl; } exp_t;
    exp_t q[$];

    initial begin
        logic [3:0]  m_flags;
        logic        m_ptr, m_busy, gid, sf;
        logic [1:0]  v, exp_rdy;
        logic [63:0] a, b;
        logic [2:0]  cn;
        int          cyc, m_acc;
        alu_out_t    o;
        exp_t        e;
        m_flags = '0; m_ptr = 1'b0; m_busy = 1'b0; cyc = 0; m_acc = 0; gid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
                chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
                chk("rst_flags", {60'd0, flags}, 64'd0);
                chk("rst_rsp", {rsp_result ^ 64'd0}, 64'd0);
                chk("rst_id_err", {62'd0, rsp_id, rsp_error}, 64'd0);
                chk("rst_alu_ops", alu_A | alu_B | {61'd0, alu_cntrl}, 64'd0);
                q.delete();
                m_busy = 1'b0; m_flags = '0; m_ptr = 1'b0;
            end else begin
                v = {req1_valid, req0_valid};
                exp_rdy = 2'b00;
                if (!m_busy && v != 2'b00) begin
                    gid = (v == 2'b11) ? m_ptr : v[1];
                    exp_rdy = gid ? 2'b10 : 2'b01;
                end
                chk("ready", {62'd0, req1_ready, req0_ready}, {62'd0, exp_rdy});
                chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_busy && (cyc - m_acc >= 2)});
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
                    end else begin
                        chk("rsp_id", {63'd0, rsp_id}, {63'd0, q[0].id});
                        chk("rsp_result", rsp_result, q[0].res);
                        chk("rsp_error", {63'd0, rsp_error}, {63'd0, q[0].err});
                        chk("flags", {60'd0, flags}, {60'd0, q[0].fl});
                        if (rsp_ready) begin
                            void'(q.pop_front());
                            m_busy = 1'b0;
                        end
                    end
                end
                if (exp_rdy != 2'b00) begin
                    a  = gid ? req1_a : req0_a;
                    b  = gid ? req1_b : req0_b;
                    cn = gid ? req1_cntrl : req0_cntrl;
                    sf = gid ? req1_setflags : req0_setflags;
                    o  = ref_alu(a, b, cn);
                    e.id = gid;
                    if (cn == 3'b001 || cn == 3'b111) begin
                        e.res = '0; e.err = 1'b1;
                    end else begin
                        e.res = o.r; e.err = 1'b0;
                        if (sf) begin
                            case (cn)
                                ALU_ADD, ALU_SUBTRACT:    m_flags = o.nzvc;
                                ALU_AND, ALU_OR, ALU_XOR: m_flags = {o.nzvc[3:2], 2'b00};
                                default: ;
                            endcase
                        end
                    end
                    e.fl = m_flags;
                    q.push_back(e);
                    m_busy = 1'b1;
                    m_acc  = cyc;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    m_ptr = ~gid;
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] cn, input logic sf, input int hold,
                        output logic [63:0] res, output logic [3:0] fl, output logic err);
        int n;
        rsp_ready = (hold == 0);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cntrl = cn; req1_setflags = sf;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cntrl = cn; req0_setflags = sf;
        end
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (id ? req1_ready : req0_ready) break;
        end
        if (n >= 20) chk("send_grant_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (hold > 0) begin
            // competing request that must stay ungranted while the response is held
            if (id) begin
                req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd9; req0_cntrl = ALU_OR; req0_setflags = 1'b1;
            end else begin
                req1_valid = 1'b1; req1_a = 64'd3; req1_b = 64'd9; req1_cntrl = ALU_OR; req1_setflags = 1'b1;
            end
        end
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (rsp_valid) break;
        end
        if (n >= 20) chk("send_rsp_timeout", 64'd0, 64'd1);
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            @(posedge clk); #1 rsp_ready = 1'b1;
            @(negedge clk);
        end
        res = rsp_result; fl = flags; err = rsp_error;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        logic [3:0]  fl;
        logic        err;
        int          grants[$];
        int          n;
        int          exp_g[4];

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        send(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 1'b1, 0, res, fl, err);
        chk("d_add_result", res, 64'h8000_0000_0000_0000);
        chk("d_add_flags", {60'd0, fl}, 64'h0A);

        send(1'b1, 64'd5, 64'd5, ALU_SUBTRACT, 1'b1, 4, res, fl, err);
        chk("d_bp_result", res, 64'd0);
        chk("d_bp_error", {63'd0, err}, 64'd0);

        send(1'b0, 64'd0, 64'd1, ALU_SUBTRACT, 1'b1, 0, res, fl, err);
        chk("d_neg_flags", {60'd0, fl}, 64'h8);
        send(1'b1, 64'd12, 64'd34, 3'b111, 1'b1, 0, res, fl, err);
        chk("d_illegal_error", {63'd0, err}, 64'd1);
        chk("d_illegal_result", res, 64'd0);
        chk("d_illegal_flags", {60'd0, fl}, 64'h8);

        send(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, ALU_ADD, 1'b1, 0, res, fl, err);
        chk("d_vc_flags", {60'd0, fl}, 64'h3);
        send(1'b1, 64'hF0, 64'h0F, ALU_AND, 1'b1, 0, res, fl, err);
        chk("d_and_result", res, 64'd0);
        chk("d_and_flags", {60'd0, fl}, 64'h4);

        // reset while the response is held
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1;
        req0_cntrl = ALU_ADD; req0_setflags = 1'b1;
        n = 0;
        while (n < 20) begin @(negedge clk); n++; if (req0_ready) break; end
        @(posedge clk); #1 req0_valid = 1'b0;
        n = 0;
        while (n < 20) begin @(negedge clk); n++; if (rsp_valid) break; end
        chk("d_pre_reset_flags", {60'd0, flags}, 64'h0A);
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        chk("d_reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("d_reset_flags", {60'd0, flags}, 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // simultaneous requests with rsp_ready held high
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_cntrl = ALU_ADD; req0_setflags = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd7; req1_b = 64'd3; req1_cntrl = ALU_XOR; req1_setflags = 1'b0;
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            @(negedge clk); n++;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        chk("d_sim_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("d_sim_grant", 64'(grants[i]), 64'(exp_g[i]));
        repeat (4) @(posedge clk);
        #1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req0_valid    = 1'($urandom_range(0, 1));
            req1_valid    = 1'($urandom_range(0, 1));
            req0_a        = ($urandom_range(0, 3) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            req0_b        = ($urandom_range(0, 3) == 0) ? req0_a : {$urandom, $urandom};
            req1_a        = ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            req1_b        = ($urandom_range(0, 3) == 0) ? req1_a : {$urandom, $urandom};
            req0_cntrl    = 3'($urandom_range(0, 7));
            req1_cntrl    = 3'($urandom_range(0, 7));
            req0_setflags = 1'($urandom_range(0, 1));
            req1_setflags = 1'($urandom_range(0, 1));
            rsp_ready     = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
